// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak/SHAKE datapath blocks.
package keccak_pkg;

  localparam int unsigned WORD_W              = 32;
  localparam int unsigned SHAKE128_RATE_WORDS = 42;
  localparam int unsigned SHAKE256_RATE_WORDS = 34;

  localparam logic [7:0] SHAKE_PAD_BYTE = 8'h1F;
  localparam logic [7:0] FINAL_PAD_BYTE = 8'h80;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/padder1.sv
// Formats the final message word: keeps byte_num leading bytes, then the SHAKE
// domain-separation byte, then zeros.
module padder1
  import keccak_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [1:0]        byte_num,
  output logic [WORD_W-1:0] out
);

  // The lowest byte is never kept: at most three message bytes precede the pad byte.
  logic unused_low_byte;
  assign unused_low_byte = ^in[7:0];

  always_comb begin
    out = {SHAKE_PAD_BYTE, 24'h000000};
    unique case (byte_num)
      2'd0: out = {SHAKE_PAD_BYTE, 24'h000000};
      2'd1: out = {in[31:24], SHAKE_PAD_BYTE, 16'h0000};
      2'd2: out = {in[31:16], SHAKE_PAD_BYTE, 8'h00};
      2'd3: out = {in[31:8], SHAKE_PAD_BYTE};
      default: out = {SHAKE_PAD_BYTE, 24'h000000};
    endcase
  end

endmodule

// File: rtl/shake_block_padder.sv
// Collects 32-bit message words into one rate block, applies SHAKE padding and
// presents the block to the permutation core with a full/ack handshake.
module shake_block_padder
  import keccak_pkg::*;
#(
  parameter int unsigned RATE_WORDS = SHAKE128_RATE_WORDS
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [WORD_W-1:0]              in,
  input  logic                           in_ready,
  input  logic                           is_last,
  input  logic [1:0]                     byte_num,
  input  logic                           f_ack,
  output logic                           buffer_full,
  output logic [RATE_WORDS*WORD_W-1:0]   out,
  output logic                           out_last
);

  localparam int unsigned BLK_W = RATE_WORDS * WORD_W;
  localparam int unsigned CNT_W = $clog2(RATE_WORDS);
  localparam logic [WORD_W-1:0] FINAL_WORD = {24'h000000, FINAL_PAD_BYTE};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BLK_W-1:0]  out_d;
  logic              full_d, last_d;
  logic              append;
  logic              at_end;
  logic [WORD_W-1:0] padded;
  logic [WORD_W-1:0] word;

  padder1 u_padder1 (
    .in       (in),
    .byte_num (byte_num),
    .out      (padded)
  );

  assign at_end = (cnt_q == CNT_W'(RATE_WORDS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACCEPT;
    else          state_q <= state_d;
  end

  // Next-state: a completed slot RATE_WORDS-1 always ends in HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCEPT: begin
        if (in_ready) begin
          if (at_end)       state_d = HOLD;
          else if (is_last) state_d = PAD;
        end
      end
      PAD:     if (at_end) state_d = HOLD;
      HOLD:    if (f_ack)  state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  // Output/datapath next values; the block is left stale after an ack.
  always_comb begin
    append = 1'b0;
    word   = in;
    out_d  = out;
    cnt_d  = cnt_q;
    full_d = buffer_full;
    last_d = out_last;
    unique case (state_q)
      ACCEPT: begin
        if (in_ready) begin
          append = 1'b1;
          if (is_last) word = at_end ? (padded | FINAL_WORD) : padded;
        end
      end
      PAD: begin
        append = 1'b1;
        word   = at_end ? FINAL_WORD : '0;
      end
      HOLD: begin
        if (f_ack) begin
          full_d = 1'b0;
          last_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (append) begin
      out_d = {out[BLK_W-WORD_W-1:0], word};
      cnt_d = at_end ? '0 : cnt_q + CNT_W'(1);
      if (at_end) begin
        full_d = 1'b1;
        last_d = (state_q == PAD) || is_last;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out         <= '0;
      cnt_q       <= '0;
      buffer_full <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      out         <= out_d;
      cnt_q       <= cnt_d;
      buffer_full <= full_d;
      out_last    <= last_d;
    end
  end

endmodule

// File: tb/tb_shake_block_padder.sv
// Bench for shake_block_padder: byte-stream padding reference model with
// directed and random message sequences.
module tb_shake_block_padder;

  localparam int unsigned RW = 42;
  localparam int unsigned BW = RW * 32;

  logic          clk;
  logic          reset_n;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          is_last;
  logic [1:0]    byte_num;
  logic          f_ack;
  logic          buffer_full;
  logic [BW-1:0] out;
  logic          out_last;

  shake_block_padder #(.RATE_WORDS(RW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in          (in_data),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .f_ack       (f_ack),
    .buffer_full (buffer_full),
    .out         (out),
    .out_last    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: message as a byte stream, padded per SHAKE rules.
  logic [7:0] mq[$];
  logic [7:0] blk[RW*4];
  bit         blk_last;
  bit         blk_ready;

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] observed=%08h expected=%08h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    return {blk[4*w], blk[4*w+1], blk[4*w+2], blk[4*w+3]};
  endfunction

  function automatic logic [31:0] out_word(input int w);
    return out[BW-1-32*w -: 32];
  endfunction

  task automatic model_word(input logic [31:0] d, input bit last, input logic [1:0] bn);
    if (!last) begin
      for (int b = 0; b < 4; b++) mq.push_back(d[31-8*b -: 8]);
    end else begin
      for (int b = 0; b < int'(bn); b++) mq.push_back(d[31-8*b -: 8]);
      mq.push_back(8'h1F);
      while ((mq.size() % (RW*4)) != 0) mq.push_back(8'h00);
      mq[mq.size()-1] = mq[mq.size()-1] | 8'h80;
    end
    if (mq.size() == RW*4) begin
      for (int i = 0; i < RW*4; i++) blk[i] = mq[i];
      blk_last  = last;
      blk_ready = 1'b1;
      mq.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [31:0] d, input bit last, input logic [1:0] bn);
    in_data  = d;
    in_ready = 1'b1;
    is_last  = last;
    byte_num = bn;
    step();
    in_ready = 1'b0;
    in_data  = $urandom;
    is_last  = 1'(($urandom));
    byte_num = 2'($urandom);
    model_word(d, last, bn);
  endtask

  task automatic ack(input string tag);
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
    chk({tag, "_ack_full"}, 0, 32'(buffer_full), 32'd0);
    chk({tag, "_ack_last"}, 0, 32'(out_last), 32'd0);
  endtask

  task automatic check_block(input string tag, input bit do_ack);
    int n = 0;
    while (buffer_full !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_full"}, n, 32'(buffer_full), 32'd1);
    chk({tag, "_last"}, 0, 32'(out_last), 32'(blk_last));
    for (int w = 0; w < RW; w++) chk({tag, "_word"}, w, out_word(w), exp_word(w));
    blk_ready = 1'b0;
    if (do_ack) ack(tag);
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] y;
    int nw;
    reset_n = 1'b0; in_data = '0; in_ready = 1'b0; is_last = 1'b0;
    byte_num = '0; f_ack = 1'b0; blk_ready = 1'b0; blk_last = 1'b0;
    #12;
    chk("rst_full", 0, 32'(buffer_full), 32'd0);
    chk("rst_last", 0, 32'(out_last), 32'd0);
    chk("rst_out", 0, 32'(|out), 32'd0);
    #3 reset_n = 1'b1;
    step();

    // 1: full non-final block with counting pattern
    for (int i = 1; i <= 41; i++) feed(32'(i), 1'b0, 2'd0);
    chk("t1_not_full", 41, 32'(buffer_full), 32'd0);
    feed(32'd42, 1'b0, 2'd0);
    chk("t1_full_next", 42, 32'(buffer_full), 32'd1);
    chk("t1_first", 0, out_word(0), 32'h00000001);
    chk("t1_lastw", 41, out_word(RW-1), 32'h0000002A);
    check_block("t1", 1'b1);

    // 2: empty message, 41 pad cycles
    feed($urandom, 1'b1, 2'd0);
    repeat (40) step();
    chk("t2_pad_busy", 40, 32'(buffer_full), 32'd0);
    step();
    chk("t2_pad_done", 41, 32'(buffer_full), 32'd1);
    chk("t2_first", 0, out_word(0), 32'h1F000000);
    chk("t2_lastw", 41, out_word(RW-1), 32'h00000080);
    check_block("t2", 1'b1);

    // 3: final word lands in the last slot
    for (int i = 0; i <= 40; i++) feed(32'(i), 1'b0, 2'd0);
    feed(32'h11223344, 1'b1, 2'd3);
    chk("t3_full", 0, 32'(buffer_full), 32'd1);
    chk("t3_lastw", 41, out_word(RW-1), 32'h1122339F);
    check_block("t3", 1'b1);

    // 4: ack and in_ready in the same cycle drop the word
    for (int i = 0; i < RW; i++) feed($urandom, 1'b0, 2'd0);
    check_block("t4a", 1'b0);
    prev = exp_word(RW-1);
    in_data = 32'hDEADBEEF; in_ready = 1'b1; is_last = 1'b0; f_ack = 1'b1;
    step();
    in_ready = 1'b0; f_ack = 1'b0;
    chk("t4_ack_full", 0, 32'(buffer_full), 32'd0);
    chk("t4_stale", 0, out_word(RW-1), prev);
    y = $urandom;
    feed(y, 1'b0, 2'd0);
    chk("t4_slot0", 0, out_word(RW-1), y);
    chk("t4_shift", 0, out_word(RW-2), prev);
    for (int i = 1; i < RW; i++) feed($urandom, 1'b0, 2'd0);
    check_block("t4b", 1'b1);

    // 5: in_ready in PAD/HOLD ignored; stray ack in ACCEPT ignored
    for (int i = 0; i < 20; i++) begin
      feed($urandom, 1'b0, 2'd0);
      if (i == 5) begin f_ack = 1'b1; step(); f_ack = 1'b0; end
    end
    feed($urandom, 1'b1, 2'($urandom));
    in_ready = 1'b1; in_data = $urandom;
    check_block("t5", 1'b0);
    repeat (3) step();
    chk("t5_hold_full", 0, 32'(buffer_full), 32'd1);
    chk("t5_hold_out", 0, out_word(RW-1), exp_word(RW-1));
    chk("t5_hold_out0", 0, out_word(0), exp_word(0));
    in_ready = 1'b0;
    ack("t5");

    // 6: asynchronous reset mid-block
    for (int i = 0; i < 10; i++) feed($urandom, 1'b0, 2'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_full", 0, 32'(buffer_full), 32'd0);
    chk("t6_last", 0, 32'(out_last), 32'd0);
    chk("t6_out", 0, 32'(|out), 32'd0);
    mq.delete();
    @(negedge clk) reset_n = 1'b1;
    step();
    for (int i = 0; i < RW; i++) feed($urandom, 1'b0, 2'd0);
    check_block("t6", 1'b1);

    // Random messages of random length with idle gaps
    for (int m = 0; m < 6; m++) begin
      nw = $urandom_range(0, 100);
      for (int i = 0; i < nw; i++) begin
        repeat ($urandom_range(0, 2)) step();
        feed($urandom, 1'b0, 2'd0);
        if (blk_ready) check_block("rnd_mid", 1'b1);
      end
      feed($urandom, 1'b1, 2'($urandom));
      check_block("rnd_end", 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shake_block_padder.md
Name: shake_block_padder

Overview:
- Sequencing controller around the SHAKE byte padder (0x1F domain-separation padding) for the NewHope Keccak datapath.
- Collects 32-bit message words into one rate-sized block.
- Applies 0x1F padding to the final partial word, zero-fills the rest of the block and ORs 0x80 into the last byte of the block.
- Presents full blocks to the Keccak permutation core with a full/ack handshake.

Parameters:
- RATE_WORDS, 42, number of 32-bit words per rate block (42 = SHAKE128 1344-bit rate; 34 = SHAKE256 1088-bit rate).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in  in  32  message word; byte 0 is in[31:24].
- in_ready  in  1  `in` is valid this cycle.
- is_last  in  1  qualifies `in` as the final word.
- byte_num  in  2  valid bytes in the final word (0..3); don't-care unless is_last.
- f_ack  in  1  permutation core has consumed the presented block.
- buffer_full  out  1  `out` holds a complete block.
- out  out  RATE_WORDS*32  block; first word is in bits [RATE_WORDS*32-1 -: 32].
- out_last  out  1  the presented block is the final, padded block of the message.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - buffer_full=0, out_last=0, out=0, word counter=0, state ACCEPT.
  - Reset may arrive mid-block; the partial message is discarded.
- States:
  - ACCEPT: taking message words.
  - PAD: zero-filling after is_last.
  - HOLD: buffer_full=1, waiting for f_ack.
- Buffer: shift register. Each appended word does out <= {out[RATE_WORDS*32-33:0], word} and increments the counter (0..RATE_WORDS-1).
- Latency: an accepted word is visible in `out` on the next cycle.
- ACCEPT:
  - A word is accepted iff in_ready=1 and state=ACCEPT.
  - When is_last=0, the appended word is `in`.
  - When is_last=1, the appended word is padder1(in, byte_num):
    - 0 bytes -> 0x1F000000
    - 1 byte -> {in[31:24], 0x1F0000}
    - 2 bytes -> {in[31:16], 0x1F00}
    - 3 bytes -> {in[31:8], 0x1F}
  - Then go to PAD.
  - The final word always occupies one slot, so there is no overflow case.
  - When the appended word fills slot RATE_WORDS-1:
    - buffer_full goes to 1 next cycle, state HOLD, counter returns to 0.
    - If that word was the last word, it is also ORed with 0x00000080 and out_last goes to 1.
- PAD:
  - Appends one word per cycle: 0x00000000, or 0x00000080 in slot RATE_WORDS-1.
  - After filling slot RATE_WORDS-1: buffer_full=1, out_last=1, state HOLD.
  - in_ready is ignored.
- HOLD:
  - in_ready is ignored; upstream must gate on buffer_full.
  - On f_ack: buffer_full=0 next cycle, out_last=0, state ACCEPT, and out is left stale.
  - f_ack together with in_ready in the same cycle: the ack is taken and the input word is dropped.
- f_ack outside HOLD: ignored.
- is_last without in_ready: ignored.
- Empty message: is_last=1 with byte_num=0 as the first word gives a block of 0x1F000000, then zeros, ending in 0x00000080.
- Back-to-back messages: the next message begins in ACCEPT after the out_last block is acked.

Decomposition:
- Shared package keccak_pkg holds:
  - SHAKE128_RATE_WORDS=42, SHAKE256_RATE_WORDS=34
  - SHAKE_PAD_BYTE=8'h1F, FINAL_PAD_BYTE=8'h80
  - state enum {ACCEPT, PAD, HOLD}
- One sub-module: instantiate the existing padder1 combinationally for final-word formatting.
- Counter, state machine and shift buffer stay in this block.

Test Plan:
1. RATE_WORDS=42: send 42 words 0x00000001..0x0000002A (is_last=0) -> buffer_full=1 one cycle after the 42nd; out[1343:1312]=0x00000001, out[31:0]=0x0000002A; out_last=0; f_ack clears buffer_full next cycle.
2. Empty message (is_last=1, byte_num=0, first word) -> after 41 PAD cycles: buffer_full=1, out_last=1, out[1343:1312]=0x1F000000, middle words 0, out[31:0]=0x00000080.
3. Words 0..40 then in=0x11223344, is_last=1, byte_num=3 in slot 41 -> same cycle-of-fill completion; out[31:0]=0x1122339F, out_last=1.
4. Full block held, then in_ready=1 with f_ack=1 in the same cycle -> word dropped, counter=0, next accepted word lands in slot 0.
5. in_ready asserted while buffer_full=1 and during PAD -> out unchanged and counter unchanged; stray f_ack in ACCEPT is ignored.
6. reset_n pulsed low mid-block (after 10 words) -> asynchronous clear of buffer_full, out_last and out to 0; a fresh 42-word message then completes normally.
